// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, two prioritised
// write ports (port 1 wins), optional same-cycle write-to-read forwarding
// and a per-register pending-write scoreboard used by decode to stall.
module regfile_sb #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   input  logic            re1,
   input  logic            re2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   output logic            stall,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic [XLEN-1:0] wd0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic            iss,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush
);

   // Register 0 has neither storage nor a pending bit.
   logic [XLEN-1:0] regs_q [1:NREG-1];
   logic [XLEN-1:0] regs_d [1:NREG-1];
   logic [NREG-1:1] pend_q;
   logic [NREG-1:1] pend_d;

   logic            wr0_ok;
   logic            wr1_ok;
   logic [AW-1:0]   ra_w   [2];
   logic [XLEN-1:0] rd_w   [2];
   logic [1:0]      busy_w;

   // A write is effective only for an in-range, non-zero address; gating with
   // rst_n keeps a write that overlaps reset from being forwarded.
   assign wr0_ok = rst_n && we0 && (wa0 != '0) && (32'(wa0) < NREG);
   assign wr1_ok = rst_n && we1 && (wa1 != '0) && (32'(wa1) < NREG);

   assign ra_w[0] = ra1;
   assign ra_w[1] = ra2;

   // Next-state: port 1 over port 0 for data; flush > issue > write-back for pending.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      for (int unsigned r = 1; r < NREG; r++) begin
         if (wr1_ok && (32'(wa1) == r)) begin
            regs_d[r] = wd1;
         end else if (wr0_ok && (32'(wa0) == r)) begin
            regs_d[r] = wd0;
         end
         if (flush) begin
            pend_d[r] = 1'b0;
         end else if (iss && (32'(iss_rd) == r)) begin
            pend_d[r] = 1'b1;
         end else if ((wr1_ok && (32'(wa1) == r)) || (wr0_ok && (32'(wa0) == r))) begin
            pend_d[r] = 1'b0;
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 1; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   // Read ports: stored value and pending bit, overridden by same-cycle writes when forwarding.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         rd_w[p]   = '0;
         busy_w[p] = 1'b0;
         for (int unsigned r = 1; r < NREG; r++) begin
            if (32'(ra_w[p]) == r) begin
               rd_w[p]   = regs_q[r];
               busy_w[p] = pend_q[r];
            end
         end
         if (BYPASS != 0) begin
            if (wr1_ok && (wa1 == ra_w[p])) begin
               rd_w[p]   = wd1;
               busy_w[p] = 1'b0;
            end else if (wr0_ok && (wa0 == ra_w[p])) begin
               rd_w[p]   = wd0;
               busy_w[p] = 1'b0;
            end
         end
      end
   end

   assign rd1   = rd_w[0];
   assign rd2   = rd_w[1];
   assign busy1 = busy_w[0];
   assign busy2 = busy_w[1];
   assign stall = (re1 & busy_w[0]) | (re2 & busy_w[1]);

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with two read ports, two prioritised write ports, optional write-to-read bypass and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined RISC-V core: decode reads operands and raises a stall when an operand's producer has not yet written back. The ALU and LSU write-back stages use the two write ports.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers; register 0 is hard-wired zero.
- AW, 5: address width; must satisfy 2**AW >= NREG.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports and scoreboard; 0 = no forwarding.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra1, ra2  in  AW  read addresses.
- re1, re2  in  1  read-port use qualifiers; they affect only `stall`.
- rd1, rd2  out  XLEN  read data (combinational).
- busy1, busy2  out  1  operand at ra1/ra2 not yet available (combinational).
- stall  out  1  (re1 & busy1) | (re2 & busy2).
- we0, wa0, wd0  in  1/AW/XLEN  write port 0 (ALU write-back).
- we1, wa1, wd1  in  1/AW/XLEN  write port 1 (LSU write-back); has priority over port 0.
- iss  in  1  issue strobe: mark register `iss_rd` as pending.
- iss_rd  in  AW  destination of the issuing instruction.
- flush  in  1  synchronous clear of all pending bits; register contents are not affected.

## Operation
- Storage: registers 1..NREG-1, each XLEN bits. pend[1..NREG-1] holds one pending bit per register. Register 0 has no storage and no pending bit.
- Write: on each clock edge, port k writes when wek=1 and wak≠0 and wak<NREG.
  - wa0==wa1 with both enabled: wd1 is stored and wd0 is discarded.
  - Addresses ≥ NREG are ignored on both write and read. A read of such an address returns 0 with busy=0.
- Read: an address of 0 returns 0 with busy=0.
  - BYPASS=1: if port 1 writes the read address in the same cycle, return wd1. Otherwise, if port 0 writes it, return wd0. Otherwise return the stored value.
  - BYPASS=0: always return the stored value.
- Scoreboard update per register r≠0, in priority order:
  1. flush=1 clears every pending bit. Any iss in the same cycle is ignored.
  2. Otherwise, if iss=1 and iss_rd==r, pend[r] is set. This wins over a write-back to r in the same cycle, because a new producer supersedes the old one.
  3. Otherwise, any enabled write to r clears pend[r].
- busyN = pend[raN], except that with BYPASS=1 busyN=0 whenever a write to raN occurs in the same cycle.
- iss with iss_rd=0 has no effect.
- Write-back to a register that is not pending is legal and simply updates its contents.

## Timing
- Reset (rst_n low, asynchronous): every register is 0 and every pending bit is 0.
  - Hence rd1=rd2=0 and busy1=busy2=stall=0 during and immediately after reset.
  - Reset asserted in the middle of a write cancels that write.
- Write latency: the value is visible on rdN in the same cycle when BYPASS=1 and the write address matches. In all cases it is visible from the stored value one cycle after the edge.
- Scoreboard latency: an iss in cycle n gives busy=1 from cycle n+1.
  - A write-back in cycle m gives busy=0 in cycle m when BYPASS=1, and in cycle m+1 when BYPASS=0.
- rd, busy and stall are purely combinational from the current-cycle inputs and state. There are no registered outputs.

## Test plan
- Reset: drive rst_n=0 asynchronously between edges, then release. All reads return 0, stall=0, and a read of x0 returns 0 at all times.
- Write/read with priority: we0=we1=1, wa0=wa1=5, wd0=0x11111111, wd1=0x22222222. With BYPASS=1, rd1 at ra1=5 is 0x22222222 in the same cycle; on the next cycle it is 0x22222222 in both modes.
- x0 protection: we0=1, wa0=0, wd0=0xFFFFFFFF, then read ra1=0. rd1=0 and busy1=0.
- Scoreboard round trip: issue x7, then on the next cycle ra1=7, re1=1 gives busy1=1 and stall=1.
  - Write-back to x7 with BYPASS=1 gives stall=0 and rd1=wd in that cycle.
  - With BYPASS=0, stall falls one cycle later.
- Simultaneous issue and write-back: iss_rd=9 together with we1=1, wa1=9 in the same cycle. The next cycle shows busy at register 9 = 1 and rd = the written value.
- Flush: issue x3 and x4, then pulse flush together with iss_rd=6. Next cycle busy=0 for x3, x4 and x6, and register contents are unchanged.
